// File: rtl/register_write_arbiter_pkg.sv
// Shared definitions for the register write arbiter.
//   - State encoding for the arbiter FSM.
//   - Data width of the shared enable-load register.
//   - clog2_f: index width helper (never returns less than 1).
package reg_arb_pkg;

  localparam int unsigned DW = 16;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
  localparam logic [1:0] ST_ACK   = 2'd2;

  typedef enum logic [1:0] {
    StIdle  = ST_IDLE,
    StWrite = ST_WRITE,
    StAck   = ST_ACK
  } arb_state_e;

  function automatic int unsigned clog2_f(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) r = i + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/register_write_arbiter_rr_pick.sv
// Combinational round-robin picker.
//   req     : per-requester request bits
//   ptr     : highest-priority index for this pick
//   any_req : at least one request is set
//   win_id  : first set request scanning ptr, ptr+1, ... modulo NREQ
module rr_pick #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic            any_req,
  output logic [IDW-1:0]  win_id
);

  always_comb begin
    int unsigned idx;
    logic [IDW-1:0] idx_w;
    any_req = 1'b0;
    win_id  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      // Modulo keeps indices below NREQ even when NREQ is not a power of two.
      idx   = (32'(ptr) + i) % NREQ;
      idx_w = IDW'(idx);
      if (!any_req && req[idx_w]) begin
        any_req = 1'b1;
        win_id  = idx_w;
      end
    end
  end

endmodule

// File: rtl/register_write_arbiter.sv
// Round-robin write arbiter for one shared 16-bit enable-load register.
// One transaction: IDLE (pick winner) -> WRITE (reg_EN=1, reg_D=winner data)
// -> ACK (one-cycle ack to winner, advance pointer) -> IDLE.
//   Clk, reset : rising-edge clock, synchronous active-low reset
//   req        : per-requester request, held until ack
//   wr_data    : flattened data, requester i at [i*DW +: DW]
//   ack        : one-cycle completion pulse to the winner
//   reg_D      : register data bus (zero outside WRITE)
//   reg_EN     : register load enable (high only in WRITE)
//   busy       : high whenever not idle
//   grant_id   : current or most recent winner
module register_write_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned DW   = reg_arb_pkg::DW,
  parameter int unsigned IDW  = reg_arb_pkg::clog2_f(NREQ)
) (
  input  logic             Clk,
  input  logic             reset,
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ*DW-1:0] wr_data,
  output logic [NREQ-1:0]  ack,
  output logic [DW-1:0]    reg_D,
  output logic             reg_EN,
  output logic             busy,
  output logic [IDW-1:0]   grant_id
);

  import reg_arb_pkg::*;

  arb_state_e     state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] grant_q, grant_d;
  logic           any_req;
  logic [IDW-1:0] win_id;

  rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr_pick (
    .req     (req),
    .ptr     (ptr_q),
    .any_req (any_req),
    .win_id  (win_id)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    unique case (state_q)
      StIdle: begin
        if (any_req) begin
          grant_d = win_id;
          state_d = StWrite;
        end
      end
      StWrite: state_d = StAck;
      StAck: begin
        // Last winner drops to lowest priority.
        ptr_d   = (grant_q == IDW'(NREQ - 1)) ? '0 : grant_q + IDW'(1);
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs decode registered state only; no combinational path from req.
  always_comb begin
    reg_D = '0;
    ack   = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (grant_q == IDW'(i)) begin
        if (state_q == StWrite) reg_D = wr_data[i*DW +: DW];
        if (state_q == StAck) ack[i] = 1'b1;
      end
    end
  end

  assign reg_EN   = (state_q == StWrite);
  assign busy     = (state_q != StIdle);
  assign grant_id = grant_q;

  always_ff @(posedge Clk) begin
    if (!reset) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
    end
  end

endmodule

// File: tb/tb_register_write_arbiter.sv
module tb_register_write_arbiter;

  localparam int N = 4;
  localparam int W = 16;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req;
  logic [W-1:0]   dat [N];
  logic [N*W-1:0] wr_data;
  logic [N-1:0]   ack;
  logic [W-1:0]   reg_d;
  logic           reg_en;
  logic           busy;
  logic [1:0]     grant_id;

  always #5 clk = ~clk;

  always_comb begin
    wr_data = '0;
    for (int i = 0; i < N; i++) wr_data[i*W +: W] = dat[i];
  end

  register_write_arbiter #(
    .NREQ (N),
    .DW   (W),
    .IDW  (2)
  ) dut (
    .Clk      (clk),
    .reset    (rst_n),
    .req      (req),
    .wr_data  (wr_data),
    .ack      (ack),
    .reg_D    (reg_d),
    .reg_EN   (reg_en),
    .busy     (busy),
    .grant_id (grant_id)
  );

  // Stand-in for the shared FF_DCE register; not cleared by reset.
  logic [W-1:0] reg_q = '0;
  always @(posedge clk) if (reg_en) reg_q <= reg_d;

  // Reference model: per-cycle expected activity. kind 0 = idle, 1 = write, 2 = ack.
  typedef struct {
    int         kind;
    logic [W-1:0] d;
    int         id;
  } exp_t;

  exp_t         expq[$];
  exp_t         cur;
  int           last_win;
  bit           prev_idle;
  logic [W-1:0] exp_q;
  int           exp_grant;
  int           total;
  int           bad;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Last winner has lowest priority: scan starting just after it.
  function automatic int rr_winner(input logic [N-1:0] r, input int last);
    int c;
    for (int k = 1; k <= N; k++) begin
      c = (last + k) % N;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  task automatic step();
    bit           rst_at;
    logic [N-1:0] r_at;
    logic [W-1:0] d_at [N];
    int           w;
    rst_at = rst_n;
    r_at   = req;
    for (int i = 0; i < N; i++) d_at[i] = dat[i];
    @(posedge clk);
    #1;
    if (cur.kind == 1) exp_q = cur.d;
    if (!rst_at) begin
      expq.delete();
      last_win  = N - 1;
      exp_grant = 0;
      cur       = '{0, '0, 0};
    end else begin
      if (prev_idle && r_at != '0) begin
        w         = rr_winner(r_at, last_win);
        last_win  = w;
        exp_grant = w;
        expq.push_back('{1, d_at[w], w});
        expq.push_back('{2, '0, w});
      end
      if (expq.size() != 0) cur = expq.pop_front();
      else cur = '{0, '0, 0};
    end
    prev_idle = (cur.kind == 0);
    check_eq("reg_EN", 32'(reg_en), 32'(cur.kind == 1));
    check_eq("reg_D", 32'(reg_d), (cur.kind == 1) ? 32'(cur.d) : 32'd0);
    check_eq("ack", 32'(ack), (cur.kind == 2) ? (32'd1 << cur.id) : 32'd0);
    check_eq("busy", 32'(busy), 32'(cur.kind != 0));
    check_eq("grant_id", 32'(grant_id), 32'(exp_grant));
    check_eq("reg_q", 32'(reg_q), 32'(exp_q));
  endtask

  task automatic drop_acked();
    if (cur.kind == 2) req[cur.id] = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    total     = 0;
    bad       = 0;
    cur       = '{0, '0, 0};
    prev_idle = 1'b1;
    last_win  = N - 1;
    exp_q     = '0;
    exp_grant = 0;
    for (int i = 0; i < N; i++) dat[i] = '0;

    // Reset held with all requests asserted.
    rst_n = 1'b0;
    req   = 4'b1111;
    step();
    step();
    rst_n = 1'b1;
    req   = '0;

    // Single write from requester 2.
    dat[2] = 16'hBEEF;
    req    = 4'b0100;
    step();
    step();
    drop_acked();
    step();
    step();

    // Fairness with all requesters held high from a fresh pointer.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) dat[i] = 16'(i);
    req = 4'b1111;
    repeat (15) step();
    req = '0;
    repeat (3) step();

    // Wrap: after granting 2, requests 3 and 0 compete; 3 must go first.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    dat[2] = 16'h2222;
    req    = 4'b0100;
    step();
    step();
    drop_acked();
    step();
    dat[0] = 16'h0A0A;
    dat[3] = 16'h3B3B;
    req    = 4'b1001;
    repeat (8) begin
      step();
      drop_acked();
    end

    // Reset in the WRITE cycle: register still loads, no ack follows.
    dat[0] = 16'h1234;
    req    = 4'b0001;
    step();
    rst_n = 1'b0;
    req   = '0;
    step();
    rst_n = 1'b1;
    step();
    dat[1] = 16'h5678;
    req    = 4'b0010;
    repeat (4) begin
      step();
      drop_acked();
    end

    // Request dropped during WRITE: transaction still completes.
    dat[0] = 16'hA5A5;
    req    = 4'b0001;
    step();
    req = '0;
    repeat (3) step();

    // Randomized requesters with occasional resets.
    repeat (400) begin
      if ($urandom_range(0, 99) == 0) begin
        rst_n = 1'b0;
        req   = '0;
      end else begin
        rst_n = 1'b1;
        if (cur.kind == 2) begin
          if ($urandom_range(0, 1) == 1) req[cur.id] = 1'b0;
          else dat[cur.id] = 16'($urandom);
        end
        for (int i = 0; i < N; i++) begin
          if (!req[i] && $urandom_range(0, 3) == 0) begin
            req[i] = 1'b1;
            dat[i] = 16'($urandom);
          end
        end
      end
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
